// File: rtl/ov7725_cfg_pkg.sv
// ---------------------------------------------------------------------------
// ov7725_cfg_pkg
// Shared types and constants for the OV7725 configuration sequencer:
//   - cfg_state_t       : sequencer FSM states
//   - SCCB_SOFT_RST_REG : COM7 register, bit7 triggers a sensor soft reset
//   - DEF_*             : default parameter values for the sequencer
//   - is_soft_reset()   : true when a {reg, value} write resets the sensor
// ---------------------------------------------------------------------------
package ov7725_cfg_pkg;

   typedef enum logic [2:0] {
      ST_PWRUP,
      ST_FETCH,
      ST_ISSUE,
      ST_WAIT,
      ST_DELAY,
      ST_DONE,
      ST_FAIL
   } cfg_state_t;

   localparam logic [7:0] SCCB_SOFT_RST_REG = 8'h12;

   localparam logic [7:0] DEF_DEV_ADDR     = 8'h42;
   localparam int         DEF_READ_CNT     = 2;
   localparam int         DEF_POWERUP_WAIT = 1_000_000;
   localparam int         DEF_RESET_WAIT   = 50_000;
   localparam int         DEF_GAP_WAIT     = 1_000;
   localparam int         DEF_MAX_RETRY    = 3;

   // A write of COM7 with bit7 set restarts the sensor, which then needs the
   // long settle time before it accepts further SCCB traffic.
   function automatic logic is_soft_reset(input logic [7:0] reg_addr,
                                          input logic [7:0] value);
      return (reg_addr == SCCB_SOFT_RST_REG) && value[7];
   endfunction

endpackage

// File: rtl/cfg_wait_timer.sv
// ---------------------------------------------------------------------------
// cfg_wait_timer
// Loadable 32-bit down-counter used for the power-up wait and the gaps
// between SCCB transactions.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   load        : load load_value this cycle
//   load_value  : cycles to wait
//   value       : current count
//   expired     : count is zero and no load is pending
// A load of 0 therefore reports expired on the cycle after the load.
// ---------------------------------------------------------------------------
module cfg_wait_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] load_value,
   output logic [31:0] value,
   output logic        expired
);

   // Count down to zero and park there until the next load.
   always_ff @(posedge clk) begin
      if (rst) begin
         value <= '0;
      end else if (load) begin
         value <= load_value;
      end else if (value != 32'd0) begin
         value <= value - 32'd1;
      end
   end

   // Masking with load keeps a stale zero from ending a freshly loaded wait.
   assign expired = !load && (value == 32'd0);

endmodule

// File: rtl/ov7725_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// ov7725_cfg_sequencer
// Walks the OV7725 configuration LUT and issues one SCCB transaction per
// entry through the byte-level I2C master, with power-up delay, soft-reset
// settle time, ID read-back checking and NACK retry.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   cfg_start       : re-run request, honoured only in DONE or FAIL
//   lut_index       : LUT address (registered)
//   lut_data        : {reg, value} for lut_index
//   lut_size        : number of LUT entries
//   i2c_req         : transaction request, held until i2c_done
//   i2c_rw          : 1 = read, 0 = write
//   i2c_dev_addr    : SCCB write address (master ORs in the read bit)
//   i2c_reg_addr    : latched register address
//   i2c_wdata       : latched write data / expected read data
//   i2c_done        : completion pulse from the master
//   i2c_ack_err     : NACK seen, valid with i2c_done
//   i2c_rdata       : read byte, valid with i2c_done
//   cfg_busy        : sequence in progress
//   cfg_done        : sticky, all entries completed
//   cfg_err         : sticky, retries exhausted
//   id_err          : sticky, ID read-back mismatch
// Build option:
//   OV7725_ID_CHECK_EN : when defined, entries 0..READ_CNT-1 are read back
//                        and compared; otherwise they are skipped entirely.
// ---------------------------------------------------------------------------
module ov7725_cfg_sequencer
   import ov7725_cfg_pkg::*;
#(
   parameter logic [7:0] DEV_ADDR     = DEF_DEV_ADDR,
   parameter int         READ_CNT     = DEF_READ_CNT,
   parameter int         POWERUP_WAIT = DEF_POWERUP_WAIT,
   parameter int         RESET_WAIT   = DEF_RESET_WAIT,
   parameter int         GAP_WAIT     = DEF_GAP_WAIT,
   parameter int         MAX_RETRY    = DEF_MAX_RETRY
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_start,
   output logic [7:0]  lut_index,
   input  logic [15:0] lut_data,
   input  logic [7:0]  lut_size,
   output logic        i2c_req,
   output logic        i2c_rw,
   output logic [7:0]  i2c_dev_addr,
   output logic [7:0]  i2c_reg_addr,
   output logic [7:0]  i2c_wdata,
   input  logic        i2c_done,
   input  logic        i2c_ack_err,
   input  logic [7:0]  i2c_rdata,
   output logic        cfg_busy,
   output logic        cfg_done,
   output logic        cfg_err,
   output logic        id_err
);

   localparam int                 RETRY_W     = $clog2(MAX_RETRY + 1);
   localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

`ifdef OV7725_ID_CHECK_EN
   localparam logic [7:0] START_INDEX = 8'd0;
`else
   localparam logic [7:0] START_INDEX = 8'(READ_CNT);
`endif

   cfg_state_t         state;
   logic [RETRY_W-1:0] retry_cnt;
   logic [RETRY_W-1:0] retry_next;
   logic               retry_pending;
   logic               is_read;
   logic               tmr_load;
   logic [31:0]        tmr_value;
   logic [31:0]        tmr_count_unused;
   logic               tmr_expired;

   assign i2c_dev_addr = DEV_ADDR;
   assign retry_next   = retry_cnt + 1'b1;

`ifdef OV7725_ID_CHECK_EN
   logic id_err_q;
   assign is_read = (lut_index < 8'(READ_CNT));
   assign id_err  = id_err_q;
`else
   logic rdata_unused;
   assign is_read      = 1'b0;
   assign id_err       = 1'b0;
   assign rdata_unused = ^i2c_rdata;
`endif

   cfg_wait_timer u_timer (
      .clk        (clk),
      .rst        (rst),
      .load       (tmr_load),
      .load_value (tmr_value),
      .value      (tmr_count_unused),
      .expired    (tmr_expired)
   );

   // Sequencer FSM. The timer load is a registered one-cycle pulse; its reset
   // value arms the power-up wait so PWRUP needs no separate entry action.
   // retry_pending remembers whether DELAY should re-issue the latched entry
   // or fetch the next one.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_PWRUP;
         lut_index     <= START_INDEX;
         i2c_req       <= 1'b0;
         i2c_rw        <= 1'b0;
         i2c_reg_addr  <= 8'd0;
         i2c_wdata     <= 8'd0;
         cfg_busy      <= 1'b1;
         cfg_done      <= 1'b0;
         cfg_err       <= 1'b0;
`ifdef OV7725_ID_CHECK_EN
         id_err_q      <= 1'b0;
`endif
         retry_cnt     <= '0;
         retry_pending <= 1'b0;
         tmr_load      <= 1'b1;
         tmr_value     <= 32'(POWERUP_WAIT);
      end else begin
         tmr_load <= 1'b0;
         case (state)
            ST_PWRUP: begin
               if (tmr_expired) state <= ST_FETCH;
            end

            ST_FETCH: begin
               if (lut_index >= lut_size) begin
                  state    <= ST_DONE;
                  cfg_done <= 1'b1;
                  cfg_busy <= 1'b0;
               end else begin
                  i2c_reg_addr <= lut_data[15:8];
                  i2c_wdata    <= lut_data[7:0];
                  i2c_rw       <= is_read;
                  retry_cnt    <= '0;
                  state        <= ST_ISSUE;
               end
            end

            ST_ISSUE: begin
               i2c_req <= 1'b1;
               state   <= ST_WAIT;
            end

            ST_WAIT: begin
               if (i2c_done) begin
                  i2c_req <= 1'b0;
                  if (i2c_ack_err) begin
                     retry_cnt <= retry_next;
                     if (retry_next == RETRY_LIMIT) begin
                        state    <= ST_FAIL;
                        cfg_err  <= 1'b1;
                        cfg_busy <= 1'b0;
                     end else begin
                        tmr_load      <= 1'b1;
                        tmr_value     <= 32'(GAP_WAIT);
                        retry_pending <= 1'b1;
                        state         <= ST_DELAY;
                     end
                  end else begin
`ifdef OV7725_ID_CHECK_EN
                     if (i2c_rw && (i2c_rdata != i2c_wdata)) id_err_q <= 1'b1;
`endif
                     tmr_load <= 1'b1;
                     if (!i2c_rw && is_soft_reset(i2c_reg_addr, i2c_wdata)) begin
                        tmr_value <= 32'(RESET_WAIT);
                     end else begin
                        tmr_value <= 32'(GAP_WAIT);
                     end
                     lut_index     <= lut_index + 8'd1;
                     retry_pending <= 1'b0;
                     state         <= ST_DELAY;
                  end
               end
            end

            ST_DELAY: begin
               if (tmr_expired) state <= retry_pending ? ST_ISSUE : ST_FETCH;
            end

            ST_DONE, ST_FAIL: begin
               if (cfg_start) begin
                  state     <= ST_FETCH;
                  lut_index <= START_INDEX;
                  cfg_done  <= 1'b0;
                  cfg_err   <= 1'b0;
                  cfg_busy  <= 1'b1;
`ifdef OV7725_ID_CHECK_EN
                  id_err_q  <= 1'b0;
`endif
               end
            end

            default: state <= ST_PWRUP;
         endcase
      end
   end

endmodule
